sar_adc_ctrl: RTL and testbench
===============================

// Module: sar_adc_ctrl
// PURPOSE
// - Digital successive-approximation sequencer inside adc_wrapper; sits directly upstream of the analog SAR core.
// - Drives the sample switch and capacitive-DAC code, and reads the comparator decision once per bit.
// - Delivers a SIZE-bit result with an end-of-conversion pulse to the Wishbone/LA register layer downstream.
// PARAMETERS
// - SIZE       10  result resolution in bits (>=2)
// - SAMPLE_CYC 4   cycles sample_o is held high per conversion (>=1)
// - AVG_LOG2   2   log2 of conversions averaged; used only with SAR_AVG_EN
// PORTS
// - wb_clk_i  in   1     single clock; all logic rising-edge
// - wb_rst_i  in   1     synchronous, active-high reset
// - soc_i     in   1     start-of-conversion request; accepted only when busy_o=0
// - cmp_i     in   1     comparator decision, synchronized upstream; 1 = vin >= vdac
// - sample_o  out  1     sample/hold switch enable
// - dac_o     out  SIZE  DAC trial code
// - busy_o    out  1     high from the cycle after soc_i is accepted through the eoc_o cycle
// - eoc_o     out  1     one-cycle end-of-conversion pulse
// - data_o    out  SIZE  last result; stable between eoc_o pulses
// BEHAVIOUR
// - Reset: state=IDLE; sample_o=0, dac_o=0, busy_o=0, eoc_o=0, data_o=0; bit pointer, counters and result cleared.
// - Reset asserted mid-conversion aborts it. The next cycle is IDLE with reset values. No eoc_o; data_o=0.
// - FSM states: IDLE -> SAMPLE -> CONV -> DONE -> IDLE.
// - IDLE: soc_i=1 at edge N gives SAMPLE at N+1. Otherwise stay in IDLE.
// - SAMPLE: sample_o=1, dac_o=0 for exactly SAMPLE_CYC cycles, then CONV.
// - CONV: runs for SIZE cycles, bit i = SIZE-1 down to 0.
//   - Each cycle: dac_o = result | (1<<i). At the end of the cycle, sample cmp_i.
//   - cmp_i=1 keeps bit i; cmp_i=0 clears it.
//   - sample_o=0 throughout CONV.
// - DONE: one cycle. data_o <= final result, eoc_o=1, dac_o=0. Next state is IDLE.
// - Latency: soc_i accepted at cycle 0 gives eoc_o at cycle SAMPLE_CYC+SIZE+1 (15 with defaults).
// - busy_o=1 in SAMPLE, CONV and DONE. soc_i while busy_o=1 (including DONE) is dropped, not queued.
// - Back-to-back: soc_i held high restarts from IDLE. Minimum period is SAMPLE_CYC+SIZE+2 cycles.
// - Boundaries:
//   - cmp_i constantly 1 gives all-ones (2^SIZE-1).
//   - cmp_i constantly 0 gives 0.
//   - No wrap or overflow: the result is built bitwise and never summed.
// CONFIGURATION
// - SAR_AVG_EN defined:
//   - A single soc_i runs 2^AVG_LOG2 back-to-back SAMPLE+CONV passes, with no IDLE in between.
//   - Results accumulate in a (SIZE+AVG_LOG2)-bit unsigned register. It is cleared when soc_i is accepted, and cannot overflow.
//   - DONE is entered only after the last pass. data_o = acc >> AVG_LOG2 (truncating).
//   - Latency: 2^AVG_LOG2*(SAMPLE_CYC+SIZE)+1 (57 with defaults).
//   - busy_o stays high throughout. Reset clears the accumulator and the pass counter.
// - SAR_AVG_EN undefined: single conversion as above. No accumulator or pass-counter logic exists.
// STRUCTURE
// - sar_pkg: state enum (IDLE, SAMPLE, CONV, DONE) and default localparams for SIZE, SAMPLE_CYC, AVG_LOG2.
// - sar_pkg: clog2-based counter width constants.
// - Sub-module sar_avg_acc: accumulator plus pass counter. Instantiated only under SAR_AVG_EN.
// - FSM, bit pointer and sample counter live in this module.
// TESTING
// - Comparator model with vin code 0x2A5, soc_i pulse at cycle 0:
//   - dac_o trace is 0x200, 0x300, 0x280, ...
//   - eoc_o is high only at cycle 15; data_o=0x2A5.
// - cmp_i tied 1 -> data_o=0x3FF. cmp_i tied 0 -> data_o=0x000. Each has exactly one eoc_o pulse.
// - soc_i re-pulsed at cycles 3, 10 and 15 of a conversion -> ignored; exactly one eoc_o; busy_o falls at cycle 16.
// - wb_rst_i asserted at cycle 8 of a conversion:
//   - Next cycle: all outputs at reset values, state IDLE.
//   - A new soc_i converts 0x155 correctly.
// - soc_i held high for 40 cycles -> eoc_o pulses at cycles 15 and 31; sample_o high for 4 cycles per conversion.
// - SAR_AVG_EN with codes 0x100, 0x101, 0x102, 0x104 across passes:
//   - acc = 0x407; data_o = 0x101.
//   - eoc_o only at cycle 57.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg: shared types and defaults for the SAR ADC sequencer.
// FSM state enum, default parameters and counter-width helper.
package sar_pkg;

  localparam int SIZE_DEF       = 10;
  localparam int SAMPLE_CYC_DEF = 4;
  localparam int AVG_LOG2_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONV,
    DONE
  } state_t;

  // Width of a counter holding 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int BIT_W_DEF = cnt_w(SIZE_DEF);
  localparam int SMP_W_DEF = cnt_w(SAMPLE_CYC_DEF);

endpackage

// File: rtl/sar_avg_acc.sv
// sar_avg_acc: sums SAR pass results and counts passes for averaging.
// Ports: i_clk, i_rst, i_clr (restart), i_add (pass done), i_val, o_sum, o_last.
import sar_pkg::*;

module sar_avg_acc #(
  parameter int SIZE     = SIZE_DEF,
  parameter int AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_add,
  input  logic [SIZE-1:0]          i_val,
  output logic [SIZE+AVG_LOG2-1:0] o_sum,
  output logic                     o_last
);

  localparam int AW = SIZE + AVG_LOG2;
  localparam int PW = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;

  logic [AW-1:0] r_acc;
  logic [PW-1:0] r_pass;

  // o_sum already includes the pass being finished this cycle.
  assign o_sum  = r_acc + AW'(i_val);
  assign o_last = (r_pass == PW'((1 << AVG_LOG2) - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_pass <= '0;
    end else if (i_clr) begin
      r_acc  <= '0;
      r_pass <= '0;
    end else if (i_add) begin
      r_acc  <= o_sum;
      r_pass <= r_pass + 1'b1;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// sar_adc_ctrl: successive-approximation sequencer for the analog SAR core.
// Ports: wb_clk_i, wb_rst_i, soc_i, cmp_i -> sample_o, dac_o, busy_o, eoc_o, data_o.
// Define SAR_AVG_EN to average 2^AVG_LOG2 passes per soc_i.
import sar_pkg::*;

module sar_adc_ctrl #(
  parameter int SIZE       = SIZE_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            soc_i,
  input  logic            cmp_i,
  output logic            sample_o,
  output logic [SIZE-1:0] dac_o,
  output logic            busy_o,
  output logic            eoc_o,
  output logic [SIZE-1:0] data_o
);

  localparam int BW = cnt_w(SIZE);
  localparam int SW = cnt_w(SAMPLE_CYC);

  state_t          r_state;
  state_t          w_next;
  logic [BW-1:0]   r_bit;
  logic [SW-1:0]   r_scnt;
  logic [SIZE-1:0] r_res;
  logic [SIZE-1:0] r_data;

  logic            w_accept;
  logic            w_smp_last;
  logic            w_bit_last;
  logic            w_pass_last;
  logic [SIZE-1:0] w_mask;
  logic [SIZE-1:0] w_final;
  logic [SIZE-1:0] w_result;

  assign w_accept   = (r_state == IDLE) && soc_i;
  assign w_smp_last = (r_scnt == SW'(SAMPLE_CYC - 1));
  assign w_bit_last = (r_bit == '0);
  assign w_mask     = SIZE'(1) << r_bit;
  // Result with the current trial bit resolved by the comparator.
  assign w_final    = cmp_i ? (r_res | w_mask) : r_res;

`ifdef SAR_AVG_EN
  logic [SIZE+AVG_LOG2-1:0] w_sum;

  sar_avg_acc #(
    .SIZE     (SIZE),
    .AVG_LOG2 (AVG_LOG2)
  ) u_acc (
    .i_clk  (wb_clk_i),
    .i_rst  (wb_rst_i),
    .i_clr  (w_accept),
    .i_add  ((r_state == CONV) && w_bit_last),
    .i_val  (w_final),
    .o_sum  (w_sum),
    .o_last (w_pass_last)
  );

  assign w_result = SIZE'(w_sum >> AVG_LOG2);
`else
  assign w_pass_last = 1'b1;
  assign w_result    = w_final;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    sample_o = 1'b0;
    dac_o    = '0;
    busy_o   = 1'b1;
    eoc_o    = 1'b0;
    unique case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (soc_i) w_next = SAMPLE;
      end
      SAMPLE: begin
        sample_o = 1'b1;
        if (w_smp_last) w_next = CONV;
      end
      CONV: begin
        dac_o = r_res | w_mask;
        if (w_bit_last) w_next = w_pass_last ? DONE : SAMPLE;
      end
      DONE: begin
        eoc_o  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_bit  <= '0;
      r_scnt <= '0;
      r_res  <= '0;
      r_data <= '0;
    end else begin
      unique case (r_state)
        SAMPLE: begin
          r_scnt <= w_smp_last ? '0 : r_scnt + 1'b1;
          r_res  <= '0;
          r_bit  <= BW'(SIZE - 1);
        end
        CONV: begin
          r_res <= w_final;
          r_bit <= r_bit - 1'b1;
          // Loaded on entry to DONE so data_o is valid with eoc_o.
          if (w_bit_last && w_pass_last) r_data <= w_result;
        end
        default: r_scnt <= '0;
      endcase
    end
  end

  assign data_o = r_data;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb_sar_adc_ctrl: scoreboard bench for sar_adc_ctrl with a comparator model.
// Expected codes are queued at soc_i and checked on each eoc_o pulse.
module tb_sar_adc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       soc;
  logic       cmp;
  logic       sample;
  logic [9:0] dac;
  logic       busy;
  logic       eoc;
  logic [9:0] data;

  logic [9:0] vin;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;
  int eoc_cnt  = 0;
  logic [9:0] sb[$];

  always #5 clk = ~clk;

  // mode 0/1: comparator tied low/high; mode 2: vin >= vdac.
  assign cmp = (mode == 2'd2) ? (vin >= dac) : mode[0];

  sar_adc_ctrl dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .soc_i    (soc),
    .cmp_i    (cmp),
    .sample_o (sample),
    .dac_o    (dac),
    .busy_o   (busy),
    .eoc_o    (eoc),
    .data_o   (data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (eoc === 1'b1) begin
      eoc_cnt++;
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("data", {22'b0, data}, {22'b0, sb.pop_front()});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      if (!busy) done = 1;
      else tick();
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  task automatic run_conv(input logic [9:0] code,
                          input logic [1:0] m,
                          input logic [9:0] exp);
    vin     = code;
    mode    = m;
    eoc_cnt = 0;
    sb.push_back(exp);
    soc = 1'b1;
    tick();
    soc = 1'b0;
    wait_idle(200);
    tick();
    chk("eoc_count", eoc_cnt, 1);
  endtask

  task automatic chk_reset_vals;
    chk("rst_sample", {31'b0, sample}, 0);
    chk("rst_dac", {22'b0, dac}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_eoc", {31'b0, eoc}, 0);
    chk("rst_data", {22'b0, data}, 0);
  endtask

  initial begin
    int smp_n;
    rst  = 1'b1;
    soc  = 1'b0;
    vin  = '0;
    mode = 2'd0;
    tick();
    tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();

    run_conv(10'h000, 2'd1, 10'h3FF);
    run_conv(10'h000, 2'd0, 10'h000);

`ifndef SAR_AVG_EN
    // Trace and latency for vin = 0x2A5.
    vin = 10'h2A5;
    mode = 2'd2;
    eoc_cnt = 0;
    sb.push_back(10'h2A5);
    soc = 1'b1;
    tick();
    soc = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5) chk("dac_c5", {22'b0, dac}, 32'h200);
      if (c == 6) chk("dac_c6", {22'b0, dac}, 32'h300);
      if (c == 7) chk("dac_c7", {22'b0, dac}, 32'h280);
      chk("sample_t", {31'b0, sample}, (c >= 1 && c <= 4) ? 1 : 0);
      chk("eoc_t", {31'b0, eoc}, (c == 15) ? 1 : 0);
      chk("busy_t", {31'b0, busy}, (c <= 15) ? 1 : 0);
      tick();
    end
    chk("eoc_count_trace", eoc_cnt, 1);

    // soc_i re-pulsed while busy is dropped.
    vin = 10'h1E7;
    eoc_cnt = 0;
    sb.push_back(10'h1E7);
    soc = 1'b1;
    tick();
    soc = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk("busy_drop", {31'b0, busy}, (c <= 15) ? 1 : 0);
      soc = (c == 3 || c == 10 || c == 15);
      tick();
    end
    soc = 1'b0;
    chk("eoc_count_drop", eoc_cnt, 1);

    // Reset mid-conversion aborts with no eoc.
    vin = 10'h3C3;
    eoc_cnt = 0;
    sb.push_back(10'h3C3);
    soc = 1'b1;
    tick();
    soc = 1'b0;
    for (int c = 1; c < 8; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals();
    sb.delete();
    for (int c = 0; c < 20; c++) tick();
    chk("eoc_count_abort", eoc_cnt, 0);
    run_conv(10'h155, 2'd2, 10'h155);

    // soc_i held high for 40 cycles.
    vin = 10'h0F0;
    eoc_cnt = 0;
    smp_n = 0;
    repeat (3) sb.push_back(10'h0F0);
    soc = 1'b1;
    tick();
    for (int c = 1; c <= 40; c++) begin
      chk("eoc_held", {31'b0, eoc}, (c == 15 || c == 31) ? 1 : 0);
      if (sample) smp_n++;
      if (c == 40) soc = 1'b0;
      tick();
    end
    chk("sample_held", smp_n, 12);
    wait_idle(200);
    tick();
    chk("eoc_count_held", eoc_cnt, 3);
`else
    // Averaging over four passes with a different code per pass.
    vin = 10'h100;
    mode = 2'd2;
    eoc_cnt = 0;
    sb.push_back(10'h101);
    soc = 1'b1;
    tick();
    soc = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 15) vin = 10'h101;
      if (c == 29) vin = 10'h102;
      if (c == 43) vin = 10'h104;
      chk("eoc_avg", {31'b0, eoc}, (c == 57) ? 1 : 0);
      chk("busy_avg", {31'b0, busy}, (c <= 57) ? 1 : 0);
      tick();
    end
    chk("eoc_count_avg", eoc_cnt, 1);
`endif

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
